// File: rtl/call_stack_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : call_stack_ctrl
// Description : CALL/RET sequencer. Owns the frame stack pointer and the
//               return-address LIFO, drives the register-file push/pop
//               strobes and loads the PC two cycles after an accepted request.
// Revision    : 1.0 - initial release
// ============================================================================
module call_stack_ctrl #(
  parameter int PC_WIDTH = 6,
  parameter int DEPTH    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cs_call,
  input  logic                cs_ret,
  input  logic [PC_WIDTH-1:0] cs_pc,
  input  logic [PC_WIDTH-1:0] cs_target,
  output logic                cs_pc_load,
  output logic [PC_WIDTH-1:0] cs_pc_next,
  output logic                cs_busy,
  output logic                rf_stack_push,
  output logic                rf_stack_pop,
  output logic [PC_WIDTH-1:0] rf_stack_pointer,
  output logic                cs_overflow,
  output logic                cs_underflow
);

  localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PC_WIDTH-1:0] C_DEPTH = PC_WIDTH'(DEPTH);
  localparam logic [PC_WIDTH-1:0] C_ONE   = PC_WIDTH'(1);
  localparam logic [PC_WIDTH-1:0] C_ZERO  = '0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PUSH  = 3'd1,
    S_CJUMP = 3'd2,
    S_POP   = 3'd3,
    S_RJUMP = 3'd4
  } state_t;

  state_t              r_state;
  logic [PC_WIDTH-1:0] r_sp;
  logic [PC_WIDTH-1:0] r_addr;
  logic [PC_WIDTH-1:0] r_ra [0:DEPTH-1];
  logic                r_push;
  logic                r_pop;
  logic                r_pc_load;
  logic [PC_WIDTH-1:0] r_pc_next;
  logic                r_busy;
  logic                r_overflow;
  logic                r_underflow;

  logic                w_call_ok;
  logic                w_ret_ok;
  logic [IDX_W-1:0]    w_wr_idx;
  logic [IDX_W-1:0]    w_rd_idx;

  // Frame n lives in LIFO slot n-1, so the slot for a new frame is the old sp.
  assign w_wr_idx  = IDX_W'(r_sp);
  assign w_rd_idx  = IDX_W'(r_sp - C_ONE);
  assign w_call_ok = (r_state == S_IDLE) && cs_call && (r_sp < C_DEPTH);
  assign w_ret_ok  = (r_state == S_IDLE) && !cs_call && cs_ret && (r_sp != C_ZERO);

  always_ff @(posedge clk) begin
    if (rst_n && w_call_ok) begin
      r_ra[w_wr_idx] <= cs_pc + C_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_sp        <= '0;
      r_addr      <= '0;
      r_push      <= 1'b0;
      r_pop       <= 1'b0;
      r_pc_load   <= 1'b0;
      r_pc_next   <= '0;
      r_busy      <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_push    <= 1'b0;
      r_pop     <= 1'b0;
      r_pc_load <= 1'b0;
      r_pc_next <= '0;
      r_busy    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cs_call) begin
            if (w_call_ok) begin
              r_sp    <= r_sp + C_ONE;
              r_addr  <= cs_target;
              r_push  <= 1'b1;
              r_busy  <= 1'b1;
              r_state <= S_PUSH;
            end else begin
              r_overflow <= 1'b1;
            end
          end else if (cs_ret) begin
            if (w_ret_ok) begin
              r_addr  <= r_ra[w_rd_idx];
              r_pop   <= 1'b1;
              r_busy  <= 1'b1;
              r_state <= S_POP;
            end else begin
              r_underflow <= 1'b1;
            end
          end
        end
        S_PUSH: begin
          r_pc_load <= 1'b1;
          r_pc_next <= r_addr;
          r_busy    <= 1'b1;
          r_state   <= S_CJUMP;
        end
        S_POP: begin
          // Pointer drops after the pop strobe so the RF restores the right frame.
          r_sp      <= r_sp - C_ONE;
          r_pc_load <= 1'b1;
          r_pc_next <= r_addr;
          r_busy    <= 1'b1;
          r_state   <= S_RJUMP;
        end
        S_CJUMP, S_RJUMP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cs_pc_load       = r_pc_load;
  assign cs_pc_next       = r_pc_next;
  assign cs_busy          = r_busy;
  assign rf_stack_push    = r_push;
  assign rf_stack_pop     = r_pop;
  assign rf_stack_pointer = r_sp;
  assign cs_overflow      = r_overflow;
  assign cs_underflow     = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_call_stack_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_call_stack_ctrl
// Description : Table vectors, directed corner sequences and random traffic
//               checked against a queue-based model of call_stack_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_call_stack_ctrl;

  localparam int PW    = 6;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cs_call;
  logic          cs_ret;
  logic [PW-1:0] cs_pc;
  logic [PW-1:0] cs_target;
  logic          cs_pc_load;
  logic [PW-1:0] cs_pc_next;
  logic          cs_busy;
  logic          rf_stack_push;
  logic          rf_stack_pop;
  logic [PW-1:0] rf_stack_pointer;
  logic          cs_overflow;
  logic          cs_underflow;

  always #5 clk = ~clk;

  call_stack_ctrl #(.PC_WIDTH(PW), .DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cs_call          (cs_call),
    .cs_ret           (cs_ret),
    .cs_pc            (cs_pc),
    .cs_target        (cs_target),
    .cs_pc_load       (cs_pc_load),
    .cs_pc_next       (cs_pc_next),
    .cs_busy          (cs_busy),
    .rf_stack_push    (rf_stack_push),
    .rf_stack_pop     (rf_stack_pop),
    .rf_stack_pointer (rf_stack_pointer),
    .cs_overflow      (cs_overflow),
    .cs_underflow     (cs_underflow)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // {push, pop, pc_load, pc_next[5:0], busy, pointer[5:0], overflow, underflow}
  function automatic logic [17:0] pk(input bit push, input bit pop, input bit load,
                                     input int unsigned nxt, input bit busy,
                                     input int unsigned ptr, input bit ovf, input bit unf);
    logic [5:0] n6;
    logic [5:0] p6;
    n6 = nxt[5:0];
    p6 = ptr[5:0];
    return {push, pop, load, n6, busy, p6, ovf, unf};
  endfunction

  function automatic logic [17:0] actual();
    return {rf_stack_push, rf_stack_pop, cs_pc_load, cs_pc_next, cs_busy,
            rf_stack_pointer, cs_overflow, cs_underflow};
  endfunction

  task automatic compare(input string name, input logic [17:0] exp);
    logic [17:0] act;
    act = actual();
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got push=%b pop=%b load=%b next=%0d busy=%b ptr=%0d ovf=%b unf=%b; expected push=%b pop=%b load=%b next=%0d busy=%b ptr=%0d ovf=%b unf=%b",
               name, $time, act[17], act[16], act[15], act[14:9], act[8], act[7:2], act[1], act[0],
               exp[17], exp[16], exp[15], exp[14:9], exp[8], exp[7:2], exp[1], exp[0]);
    end
  endtask

  // Reference model: a LIFO of return addresses plus a cycle count within the
  // current transfer (0 = idle, 1 = strobe cycle, 2 = PC-load cycle).
  int unsigned m_stack[$];
  int          m_phase = 0;
  bit          m_is_call = 1'b0;
  int unsigned m_addr = 0;
  bit          m_ovf = 1'b0;
  bit          m_unf = 1'b0;
  logic [17:0] m_exp;

  task automatic model_step(input bit rn, input bit c, input bit r,
                            input int unsigned pc, input int unsigned tgt);
    bit e_push, e_pop, e_load, e_busy;
    int unsigned e_next;
    e_push = 0; e_pop = 0; e_load = 0; e_busy = 0; e_next = 0;
    if (!rn) begin
      m_stack.delete();
      m_phase = 0;
      m_ovf   = 0;
      m_unf   = 0;
    end else begin
      case (m_phase)
        0: begin
          if (c) begin
            if (m_stack.size() < DEPTH) begin
              m_stack.push_back((pc + 1) % 64);
              m_addr = tgt; m_is_call = 1; m_phase = 1;
              e_push = 1; e_busy = 1;
            end else m_ovf = 1;
          end else if (r) begin
            if (m_stack.size() > 0) begin
              m_addr = m_stack[$]; m_is_call = 0; m_phase = 1;
              e_pop = 1; e_busy = 1;
            end else m_unf = 1;
          end
        end
        1: begin
          if (!m_is_call) void'(m_stack.pop_back());
          e_load = 1; e_next = m_addr; e_busy = 1; m_phase = 2;
        end
        default: m_phase = 0;
      endcase
    end
    m_exp = pk(e_push, e_pop, e_load, e_next, e_busy, m_stack.size(), m_ovf, m_unf);
  endtask

  task automatic cycle(input string tag, input bit rn, input bit c, input bit r,
                       input int unsigned pc, input int unsigned tgt);
    rst_n     = rn;
    cs_call   = c;
    cs_ret    = r;
    cs_pc     = pc[PW-1:0];
    cs_target = tgt[PW-1:0];
    @(posedge clk);
    #1;
    model_step(rn, c, r, pc, tgt);
    compare(tag, m_exp);
  endtask

  task automatic do_call(input string tag, input int unsigned pc, input int unsigned tgt);
    cycle(tag, 1, 1, 0, pc, tgt);
    cycle(tag, 1, 0, 0, 0, 0);
    cycle(tag, 1, 0, 0, 0, 0);
  endtask

  task automatic do_ret(input string tag);
    cycle(tag, 1, 0, 1, 0, 0);
    cycle(tag, 1, 0, 0, 0, 0);
    cycle(tag, 1, 0, 0, 0, 0);
  endtask

  typedef struct {
    bit          rn;
    bit          c;
    bit          r;
    int unsigned pc;
    int unsigned tgt;
    logic [17:0] exp;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(input bit rn, input bit c, input bit r,
                              input int unsigned pc, input int unsigned tgt,
                              input logic [17:0] exp);
    vec_t v;
    v.rn = rn; v.c = c; v.r = r; v.pc = pc; v.tgt = tgt; v.exp = exp;
    return v;
  endfunction

  initial begin
    // Expected outputs after the edge that samples each row's inputs.
    tbl[0]  = mk(0, 0, 0,  0,  0, pk(0, 0, 0,  0, 0, 0, 0, 0));
    tbl[1]  = mk(0, 1, 1,  3,  9, pk(0, 0, 0,  0, 0, 0, 0, 0));
    tbl[2]  = mk(1, 1, 0,  5, 20, pk(1, 0, 0,  0, 1, 1, 0, 0));
    tbl[3]  = mk(1, 0, 0,  0,  0, pk(0, 0, 1, 20, 1, 1, 0, 0));
    tbl[4]  = mk(1, 0, 0,  0,  0, pk(0, 0, 0,  0, 0, 1, 0, 0));
    tbl[5]  = mk(1, 0, 1,  0,  0, pk(0, 1, 0,  0, 1, 1, 0, 0));
    tbl[6]  = mk(1, 0, 0,  0,  0, pk(0, 0, 1,  6, 1, 0, 0, 0));
    tbl[7]  = mk(1, 0, 0,  0,  0, pk(0, 0, 0,  0, 0, 0, 0, 0));
    tbl[8]  = mk(1, 0, 1,  0,  0, pk(0, 0, 0,  0, 0, 0, 0, 1));
    tbl[9]  = mk(1, 1, 0, 63,  7, pk(1, 0, 0,  0, 1, 1, 0, 1));
    tbl[10] = mk(1, 0, 0,  0,  0, pk(0, 0, 1,  7, 1, 1, 0, 1));
    tbl[11] = mk(1, 0, 0,  0,  0, pk(0, 0, 0,  0, 0, 1, 0, 1));
    tbl[12] = mk(1, 0, 1,  0,  0, pk(0, 1, 0,  0, 1, 1, 0, 1));
    tbl[13] = mk(1, 0, 0,  0,  0, pk(0, 0, 1,  0, 1, 0, 0, 1));
    tbl[14] = mk(1, 0, 0,  0,  0, pk(0, 0, 0,  0, 0, 0, 0, 1));
    tbl[15] = mk(1, 1, 0,  5, 20, pk(1, 0, 0,  0, 1, 1, 0, 1));
    tbl[16] = mk(0, 0, 0,  0,  0, pk(0, 0, 0,  0, 0, 0, 0, 0));
    tbl[17] = mk(1, 0, 0,  0,  0, pk(0, 0, 0,  0, 0, 0, 0, 0));
    tbl[18] = mk(1, 0, 0,  0,  0, pk(0, 0, 0,  0, 0, 0, 0, 0));

    rst_n = 1'b0; cs_call = 1'b0; cs_ret = 1'b0; cs_pc = '0; cs_target = '0;

    for (int i = 0; i < 19; i++) begin
      cycle($sformatf("table_model[%0d]", i), tbl[i].rn, tbl[i].c, tbl[i].r, tbl[i].pc, tbl[i].tgt);
      compare($sformatf("table[%0d]", i), tbl[i].exp);
    end

    // Nest to full depth, overflow, then unwind in LIFO order.
    for (int i = 1; i <= DEPTH; i++) do_call($sformatf("nest_call%0d", i), i, i * 4);
    compare("nest_full_ptr", pk(0, 0, 0, 0, 0, DEPTH, 0, 0));
    cycle("overflow_req", 1, 1, 0, 30, 40);
    compare("overflow_flag", pk(0, 0, 0, 0, 0, DEPTH, 1, 0));
    cycle("overflow_idle", 1, 0, 0, 0, 0);
    cycle("ret_after_ovf", 1, 0, 1, 0, 0);
    compare("ret_after_ovf_pop", pk(0, 1, 0, 0, 1, DEPTH, 1, 0));
    cycle("ret_after_ovf", 1, 0, 0, 0, 0);
    compare("ret_after_ovf_ra", pk(0, 0, 1, DEPTH + 1, 1, DEPTH - 1, 1, 0));
    cycle("ret_after_ovf", 1, 0, 0, 0, 0);
    for (int i = DEPTH - 1; i >= 1; i--) do_ret($sformatf("nest_ret%0d", i));
    compare("nest_empty", pk(0, 0, 0, 0, 0, 0, 1, 0));

    // CALL and RET together at sp=2: only the CALL runs.
    do_call("sim_pre1", 10, 11);
    do_call("sim_pre2", 12, 13);
    cycle("sim_both", 1, 1, 1, 14, 50);
    compare("sim_both_push3", pk(1, 0, 0, 0, 1, 3, 1, 0));
    cycle("sim_both", 1, 0, 0, 0, 0);
    cycle("sim_both", 1, 0, 0, 0, 0);

    // RET held through the busy cycles of a CALL is taken once, at idle.
    cycle("held_call", 1, 1, 0, 20, 33);
    cycle("held_busy1", 1, 0, 1, 0, 0);
    cycle("held_busy2", 1, 0, 1, 0, 0);
    cycle("held_accept", 1, 0, 1, 0, 0);
    compare("held_pop4", pk(0, 1, 0, 0, 1, 4, 1, 0));
    cycle("held_drop", 1, 0, 0, 0, 0);
    compare("held_ra21", pk(0, 0, 1, 21, 1, 3, 1, 0));
    cycle("held_idle", 1, 0, 0, 0, 0);
    cycle("held_idle2", 1, 0, 0, 0, 0);
    compare("held_once", pk(0, 0, 0, 0, 0, 3, 1, 0));

    // Random traffic, call-heavy first half to reach full depth.
    for (int i = 0; i < 600; i++) begin
      bit rn, c, r;
      rn = ($urandom_range(0, 149) != 0);
      c  = (i < 300) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 3) == 0);
      r  = ($urandom_range(0, 2) == 0);
      cycle($sformatf("rand[%0d]", i), rn, c, r, $urandom_range(0, 63), $urandom_range(0, 63));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
